// File: rtl/sr_latch_pkg.sv
// Shared encodings and helpers for the clocked SR latch bank.
package sr_latch_pkg;

  // Rules for resolving a cell whose set and reset are both asserted
  localparam int unsigned SR_RST_DOM = 0;
  localparam int unsigned SR_SET_DOM = 1;
  localparam int unsigned SR_HOLD    = 2;
  localparam int unsigned SR_TOGGLE  = 3;

  // Width needed to count 0..filterCycles without wrapping
  function automatic int unsigned filterCntWidth(input int unsigned filterCycles);
    return $clog2(filterCycles + 1);
  endfunction

endpackage

// File: rtl/sr_input_filter.sv
// One-bit synchroniser followed by a consecutive-cycle glitch filter.
module sr_input_filter
  import sr_latch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic notRst,
  input  logic rawIn,
  output logic filtered
);

  localparam int unsigned CntW = filterCntWidth(FILTER_CYCLES);

  logic [SYNC_STAGES-1:0] syncQ;
  logic [CntW-1:0]        cntQ, cntD;
  logic                   filtQ, filtD;
  logic                   synced;

  assign synced   = syncQ[SYNC_STAGES-1];
  assign filtered = filtQ;

  // The filtered value follows on the edge the count would reach FILTER_CYCLES
  always_comb begin
    filtD = filtQ;
    cntD  = '0;
    if (synced != filtQ) begin
      if (cntQ == CntW'(FILTER_CYCLES - 1)) begin
        filtD = synced;
      end else begin
        cntD = cntQ + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge notRst) begin
    if (!notRst) begin
      syncQ <= '1;
      cntQ  <= '0;
      filtQ <= 1'b1;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], rawIn};
      cntQ  <= cntD;
      filtQ <= filtD;
    end
  end

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of independent clocked SR cells fed by filtered active-low set/reset inputs.
module sr_latch_bank
  import sr_latch_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned MODE          = 0
) (
  input  logic                clk,
  input  logic                notRst,
  input  logic [CHANNELS-1:0] notS,
  input  logic [CHANNELS-1:0] notR,
  input  logic                clearAll,
  output logic [CHANNELS-1:0] Q,
  output logic [CHANNELS-1:0] notQ,
  output logic [CHANNELS-1:0] setPulse,
  output logic [CHANNELS-1:0] resetPulse,
  output logic [CHANNELS-1:0] invalid
);

  logic [CHANNELS-1:0] fs, fr;
  logic [CHANNELS-1:0] qQ, qD;
  logic [CHANNELS-1:0] bothQ;
  logic [CHANNELS-1:0] setPulseQ, resetPulseQ;

  for (genvar i = 0; i < CHANNELS; i++) begin : gen_filters
    sr_input_filter #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filt_s (
      .clk     (clk),
      .notRst  (notRst),
      .rawIn   (notS[i]),
      .filtered(fs[i])
    );

    sr_input_filter #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filt_r (
      .clk     (clk),
      .notRst  (notRst),
      .rawIn   (notR[i]),
      .filtered(fr[i])
    );
  end

  assign invalid = ~fs & ~fr;

  always_comb begin
    qD = qQ;
    for (int i = 0; i < CHANNELS; i++) begin
      unique case ({fs[i], fr[i]})
        2'b01:   qD[i] = 1'b1;
        2'b10:   qD[i] = 1'b0;
        2'b11:   qD[i] = qQ[i];
        default: begin
          case (MODE)
            SR_RST_DOM: qD[i] = 1'b0;
            SR_SET_DOM: qD[i] = 1'b1;
            // Toggle only on the first edge of a both-asserted run
            SR_TOGGLE:  qD[i] = bothQ[i] ? qQ[i] : ~qQ[i];
            default:    qD[i] = qQ[i];
          endcase
        end
      endcase
    end
    if (clearAll) begin
      qD = '0;
    end
  end

  always_ff @(posedge clk or negedge notRst) begin
    if (!notRst) begin
      qQ          <= '0;
      bothQ       <= '0;
      setPulseQ   <= '0;
      resetPulseQ <= '0;
    end else begin
      qQ          <= qD;
      bothQ       <= invalid;
      setPulseQ   <= qD & ~qQ;
      resetPulseQ <= ~qD & qQ;
    end
  end

  assign Q          = qQ;
  assign notQ       = ~qQ;
  assign setPulse   = setPulseQ;
  assign resetPulse = resetPulseQ;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Directed table-driven bench: one bank instance per conflict mode, shared stimulus.
module tb_sr_latch_bank;

  logic       clk = 1'b0;
  logic       notRst;
  logic [3:0] notS, notR;
  logic       clearAll;

  logic [3:0] qM[4], notQM[4], setM[4], rstM[4], invM[4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : gen_dut
    sr_latch_bank #(
      .CHANNELS     (4),
      .SYNC_STAGES  (2),
      .FILTER_CYCLES(4),
      .MODE         (m)
    ) dut (
      .clk       (clk),
      .notRst    (notRst),
      .notS      (notS),
      .notR      (notR),
      .clearAll  (clearAll),
      .Q         (qM[m]),
      .notQ      (notQM[m]),
      .setPulse  (setM[m]),
      .resetPulse(rstM[m]),
      .invalid   (invM[m])
    );
  end

  typedef struct {
    logic [3:0] notS;
    logic [3:0] notR;
    logic       clr;
    int         cycles;
    logic [3:0] q;
    logic [3:0] setP;
    logic [3:0] rstP;
    logic [3:0] inv;
  } vec_t;

  vec_t vecs[$];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkAll(input int m, input string tag, input logic [3:0] eq,
                          input logic [3:0] es, input logic [3:0] er, input logic [3:0] ei);
    chk($sformatf("%s_m%0d_q", tag, m), qM[m], eq);
    chk($sformatf("%s_m%0d_notq", tag, m), notQM[m], ~eq);
    chk($sformatf("%s_m%0d_set", tag, m), setM[m], es);
    chk($sformatf("%s_m%0d_rst", tag, m), rstM[m], er);
    chk($sformatf("%s_m%0d_inv", tag, m), invM[m], ei);
  endtask

  initial begin
    logic [3:0] expB[4];
    logic [3:0] expD[4];

    // Vectors start from a clean bank: Q=0, all inputs released
    vecs.push_back('{4'hE, 4'hF, 1'b0, 6, 4'h0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'hE, 4'hF, 1'b0, 1, 4'h1, 4'h1, 4'h0, 4'h0});
    vecs.push_back('{4'hE, 4'hF, 1'b0, 3, 4'h1, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'hF, 4'hE, 1'b0, 6, 4'h1, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'hF, 4'hE, 1'b0, 1, 4'h0, 4'h0, 4'h1, 4'h0});
    vecs.push_back('{4'hF, 4'hE, 1'b0, 3, 4'h0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'hD, 4'hF, 1'b0, 3, 4'h0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'hF, 4'hF, 1'b0, 8, 4'h0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'hD, 4'hF, 1'b0, 4, 4'h0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'hF, 4'hF, 1'b0, 2, 4'h0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'hF, 4'hF, 1'b0, 1, 4'h2, 4'h2, 4'h0, 4'h0});
    vecs.push_back('{4'hF, 4'hF, 1'b0, 8, 4'h2, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'h6, 4'hF, 1'b0, 7, 4'hB, 4'h9, 4'h0, 4'h0});
    vecs.push_back('{4'hE, 4'hF, 1'b0, 8, 4'hB, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'hE, 4'hF, 1'b1, 1, 4'h0, 4'h0, 4'hB, 4'h0});
    vecs.push_back('{4'hE, 4'hF, 1'b0, 1, 4'h1, 4'h1, 4'h0, 4'h0});
    vecs.push_back('{4'hF, 4'hF, 1'b0, 8, 4'h1, 4'h0, 4'h0, 4'h0});

    // Reset held with set asserted
    notRst   = 1'b0;
    notS     = 4'h0;
    notR     = 4'hF;
    clearAll = 1'b0;
    step(3);
    for (int m = 0; m < 4; m++) checkAll(m, "rst_hold", 4'h0, 4'h0, 4'h0, 4'h0);

    notRst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      chk($sformatf("rel_edge%0d_set", k), setM[0], 4'h0);
      chk($sformatf("rel_edge%0d_q", k), qM[0], 4'h0);
    end
    step(1);
    checkAll(0, "rel_edge7", 4'hF, 4'hF, 4'h0, 4'h0);
    step(1);
    checkAll(0, "rel_edge8", 4'hF, 4'h0, 4'h0, 4'h0);

    notS   = 4'hF;
    notRst = 1'b0;
    #2;
    notRst = 1'b1;

    // Set/reset latency, glitch rejection, clearAll
    foreach (vecs[i]) begin
      notS     = vecs[i].notS;
      notR     = vecs[i].notR;
      clearAll = vecs[i].clr;
      step(vecs[i].cycles);
      checkAll(0, $sformatf("vec%0d", i), vecs[i].q, vecs[i].setP, vecs[i].rstP, vecs[i].inv);
      for (int m = 1; m < 4; m++) chk($sformatf("vec%0d_m%0d_q", i, m), qM[m], vecs[i].q);
    end
    clearAll = 1'b0;

    // Conflict with Q[2]=1 beforehand
    notS = 4'hB;
    step(7);
    notS = 4'hF;
    step(8);
    for (int m = 0; m < 4; m++) chk($sformatf("pre1_m%0d_q", m), qM[m], 4'h5);
    notS = 4'hB;
    notR = 4'hB;
    step(6);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("cf1_m%0d_inv", m), invM[m], 4'h4);
      chk($sformatf("cf1_m%0d_qpre", m), qM[m], 4'h5);
    end
    expB = '{4'h1, 4'h5, 4'h5, 4'h1};
    for (int k = 0; k < 14; k++) begin
      step(1);
      for (int m = 0; m < 4; m++) begin
        chk($sformatf("cf1_c%0d_m%0d_q", k, m), qM[m], expB[m]);
        chk($sformatf("cf1_c%0d_m%0d_inv", k, m), invM[m], 4'h4);
      end
    end
    notS = 4'hF;
    notR = 4'hF;
    step(7);
    for (int m = 0; m < 4; m++) checkAll(m, "cf1_rel", expB[m], 4'h0, 4'h0, 4'h0);

    // Conflict with Q[2]=0 beforehand
    notR = 4'hB;
    step(7);
    notR = 4'hF;
    step(8);
    for (int m = 0; m < 4; m++) chk($sformatf("pre2_m%0d_q", m), qM[m], 4'h1);
    notS = 4'hB;
    notR = 4'hB;
    step(6);
    expD = '{4'h1, 4'h5, 4'h1, 4'h5};
    for (int k = 0; k < 14; k++) begin
      step(1);
      for (int m = 0; m < 4; m++) begin
        chk($sformatf("cf2_c%0d_m%0d_q", k, m), qM[m], expD[m]);
        chk($sformatf("cf2_c%0d_m%0d_inv", k, m), invM[m], 4'h4);
      end
    end
    notS = 4'hF;
    notR = 4'hF;
    step(8);

    // Reset on cycle 3 of a filter count, then a full restart
    notS = 4'h7;
    step(5);
    notRst = 1'b0;
    #1;
    for (int m = 0; m < 4; m++) checkAll(m, "midrst", 4'h0, 4'h0, 4'h0, 4'h0);
    #2;
    notRst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      chk($sformatf("midrst_edge%0d_q", k), qM[0], 4'h0);
    end
    step(1);
    checkAll(0, "midrst_edge7", 4'h8, 4'h8, 4'h0, 4'h0);
    notS = 4'hF;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
